cache_lsu: RTL and testbench
============================

CACHE_LSU -- requirements
Module: cache_lsu

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 2, max in-flight reads (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, response-wait limit; width 8.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_vld_i/req_rdy_o  in/out  1/1  core request handshake.
REQ-006 SHALL have port req_addr_i  input  32  byte address.
REQ-007 SHALL have port req_we_i/req_unsigned_i  input  1/1  store select / zero-extend load.
REQ-008 SHALL have port req_size_i  input  2  0=byte, 1=half, 2=word, 3=reserved.
REQ-009 SHALL have port req_wdat_i  input  32  store data, right-justified.
REQ-010 SHALL have port rsp_vld_o/rsp_rdy_i  out/in  1/1  load response handshake.
REQ-011 SHALL have port rsp_data_o  output  32  aligned, extended load data.
REQ-012 SHALL have port err_o  output  1  one-cycle pulse: misaligned/reserved-size request.
REQ-013 SHALL have port timeout_o  output  1  sticky response-timeout flag.
REQ-014 SHALL have ports p0_uvld_o, p0_urdy_i, p0_addr_o[31:0], p0_web_o, p0_wdat_o[31:0], p0_wmask_o[3:0]  cache request side.
REQ-015 SHALL have ports p0_dvld_i, p0_drdy_o, p0_ddat_i[31:0]  cache read-data side.

Function
REQ-016 SHALL register accepted requests into a single-entry request stage; req_rdy_o = stage empty, or stage draining this cycle (p0_uvld_o & p0_urdy_i) and no read-credit stall.
REQ-017 SHALL drive p0_uvld_o from the stage; hold p0_addr_o/web/wdat/wmask stable until p0_urdy_i.
REQ-018 SHALL drive p0_addr_o = {req_addr_i[31:2],2'b00}; p0_web_o = !req_we_i (0 = write).
REQ-019 SHALL replicate store data per size (byte x4, half x2) and set wmask: byte 4'b0001<<a[1:0], half 4'b0011<<a[1:0], word 4'b1111; loads wmask 4'b0000.
REQ-020 SHALL reject (not issue) requests with half at a[0]=1, word at a[1:0]!=0, or size 3: consume on handshake, pulse err_o next cycle, no response.
REQ-021 SHALL push {a[1:0], size, unsigned} into the metadata FIFO when a read is issued to the cache; stores push nothing and complete on p0 handshake.
REQ-022 SHALL not issue a read when FIFO holds MAX_OUTSTANDING entries; stores still issue.
REQ-023 SHALL drive p0_drdy_o = !rsp_vld_o | rsp_rdy_i; on p0_dvld_i & p0_drdy_o pop FIFO head, register shifted/extended data, assert rsp_vld_o next cycle.
REQ-024 SHALL extract byte/half from p0_ddat_i >> (8*a[1:0]); sign-extend unless unsigned.
REQ-025 SHALL hold rsp_vld_o/rsp_data_o until rsp_rdy_i; responses in issue order.
REQ-026 SHALL allow simultaneous FIFO push and pop in one cycle, including when full (pop frees slot).
REQ-027 SHALL ignore p0_dvld_i while FIFO empty (no pop, no response).

Reset
REQ-028 SHALL on reset clear stage, FIFO pointers/count, timeout counter; req_rdy_o=0 during reset, 1 after; p0_uvld_o=0, rsp_vld_o=0, err_o=0, timeout_o=0, rsp_data_o=0, p0 data outputs 0.
REQ-029 SHALL discard in-flight requests/responses on reset mid-operation; late p0_dvld_i ignored per REQ-027.

Configuration
REQ-030 SHALL, with CACHE_LSU_TIMEOUT_EN defined, count cycles FIFO non-empty without a pop, clear on pop, set timeout_o when count reaches TIMEOUT_CYCLES, clear timeout_o only by reset.
REQ-031 SHALL, without CACHE_LSU_TIMEOUT_EN, tie timeout_o to 0 and omit counter logic.

Structure
REQ-032 SHALL place size enum (SZ_B/SZ_H/SZ_W) and read-metadata packed struct in shared package cache_pkg.
REQ-033 SHALL implement the metadata queue as sub-module cache_lsu_fifo (parameterised depth/width, push/pop/full/empty).

Verification
REQ-034 SHALL cover: load byte a=0x103, unsigned=0, ddat=0x80AABBCC -> p0_addr=0x100, wmask=0, rsp_data=0xFFFFFF80.
REQ-035 SHALL cover: store half a=0x22, wdat=0x1234 -> p0_web=0, wmask=4'b1100, wdat=0x12341234, no rsp_vld.
REQ-036 SHALL cover: word load a=0x2 -> err_o one pulse, p0_uvld_o stays 0, no response.
REQ-037 SHALL cover: 3 back-to-back loads, MAX_OUTSTANDING=2, dvld withheld -> third not issued until first dvld; responses return in order.
REQ-038 SHALL cover: rsp_rdy_i=0 with response held -> p0_drdy_o=0, rsp_data stable until rsp_rdy_i=1.
REQ-039 SHALL cover (CACHE_LSU_TIMEOUT_EN, TIMEOUT_CYCLES=10): load issued, no dvld -> timeout_o=1 after 10 cycles, stays 1 until reset.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and data-path helpers for the cache load/store unit.
package cache_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  typedef struct packed {
    logic [1:0] off;
    size_e      size;
    logic       uns;
  } rd_meta_t;

  localparam int META_W = $bits(rd_meta_t);

  function automatic logic [31:0] store_rep(input logic [1:0] sz, input logic [31:0] w);
    case (sz)
      SZ_B:    store_rep = {4{w[7:0]}};
      SZ_H:    store_rep = {2{w[15:0]}};
      default: store_rep = w;
    endcase
  endfunction

  function automatic logic [3:0] store_mask(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      SZ_B:    store_mask = 4'b0001 << off;
      SZ_H:    store_mask = 4'b0011 << off;
      default: store_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] load_align(input logic [31:0] d, input rd_meta_t m);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{m.off, 3'b000} +: 8];
    h = d[{m.off[1], 4'b0000} +: 16];
    case (m.size)
      SZ_B:    load_align = m.uns ? {24'd0, b} : {{24{b[7]}}, b};
      SZ_H:    load_align = m.uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: load_align = d;
    endcase
  endfunction

endpackage

// File: rtl/cache_lsu_if.sv
// Core request/response and cache port bundle for cache_lsu.
interface cache_lsu_if;
  logic        req_vld_i;
  logic        req_rdy_o;
  logic [31:0] req_addr_i;
  logic        req_we_i;
  logic        req_unsigned_i;
  logic [1:0]  req_size_i;
  logic [31:0] req_wdat_i;
  logic        rsp_vld_o;
  logic        rsp_rdy_i;
  logic [31:0] rsp_data_o;
  logic        err_o;
  logic        timeout_o;
  logic        p0_uvld_o;
  logic        p0_urdy_i;
  logic [31:0] p0_addr_o;
  logic        p0_web_o;
  logic [31:0] p0_wdat_o;
  logic [3:0]  p0_wmask_o;
  logic        p0_dvld_i;
  logic        p0_drdy_o;
  logic [31:0] p0_ddat_i;

  modport slave (
    input  req_vld_i, req_addr_i, req_we_i, req_unsigned_i, req_size_i, req_wdat_i,
           rsp_rdy_i, p0_urdy_i, p0_dvld_i, p0_ddat_i,
    output req_rdy_o, rsp_vld_o, rsp_data_o, err_o, timeout_o,
           p0_uvld_o, p0_addr_o, p0_web_o, p0_wdat_o, p0_wmask_o, p0_drdy_o
  );

  modport master (
    output req_vld_i, req_addr_i, req_we_i, req_unsigned_i, req_size_i, req_wdat_i,
           rsp_rdy_i, p0_urdy_i, p0_dvld_i, p0_ddat_i,
    input  req_rdy_o, rsp_vld_o, rsp_data_o, err_o, timeout_o,
           p0_uvld_o, p0_addr_o, p0_web_o, p0_wdat_o, p0_wmask_o, p0_drdy_o
  );
endinterface

// File: rtl/cache_lsu_fifo.sv
// Read-metadata queue: circular buffer with occupancy count, push and pop allowed together.
module cache_lsu_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt;
  logic             push_ok, pop_ok;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    nxt = (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop_ok  = pop & !empty;
  assign push_ok = push & (!full | pop_ok);
  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= nxt(wr_ptr);
      if (pop_ok)  rd_ptr <= nxt(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/cache_lsu.sv
// Load/store unit between core and cache port p0; single request stage, in-order reads.
// Optional response timeout monitor enabled by defining CACHE_LSU_TIMEOUT_EN.
module cache_lsu
  import cache_pkg::*;
#(
  parameter int         MAX_OUTSTANDING = 2,
  parameter logic [7:0] TIMEOUT_CYCLES  = 8'd255
) (
  input logic        clk,
  input logic        reset,
  cache_lsu_if.slave bus
);

  logic        rdy_en;
  logic        stg_vld;
  logic [31:0] stg_addr;
  logic        stg_web;
  logic [31:0] stg_wdat;
  logic [3:0]  stg_wmask;
  rd_meta_t    stg_meta;
  logic        err_q;
  logic        rsp_vld;
  logic [31:0] rsp_data;

  logic        fifo_full, fifo_empty;
  rd_meta_t    head;
  logic        push, pop, issue, rd_stall, accept, bad, uvld, req_rdy;

  assign bad = (bus.req_size_i == 2'd3) ||
               ((bus.req_size_i == SZ_H) && bus.req_addr_i[0]) ||
               ((bus.req_size_i == SZ_W) && (bus.req_addr_i[1:0] != 2'b00));

  // A read waits for a free metadata slot; a pop in the same cycle frees one.
  assign pop      = bus.p0_dvld_i & bus.p0_drdy_o & !fifo_empty;
  assign rd_stall = stg_web & fifo_full & !pop;
  assign uvld     = stg_vld & !rd_stall;
  assign issue    = uvld & bus.p0_urdy_i;
  assign push     = issue & stg_web;
  assign req_rdy  = rdy_en & (!stg_vld | issue);
  assign accept   = bus.req_vld_i & req_rdy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_en    <= 1'b0;
      stg_vld   <= 1'b0;
      stg_addr  <= '0;
      stg_web   <= 1'b0;
      stg_wdat  <= '0;
      stg_wmask <= '0;
      stg_meta  <= '0;
      err_q     <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      err_q  <= accept & bad;
      if (accept && !bad) begin
        stg_vld   <= 1'b1;
        stg_addr  <= {bus.req_addr_i[31:2], 2'b00};
        stg_web   <= !bus.req_we_i;
        stg_wdat  <= store_rep(bus.req_size_i, bus.req_wdat_i);
        stg_wmask <= bus.req_we_i ? store_mask(bus.req_size_i, bus.req_addr_i[1:0]) : 4'b0000;
        stg_meta  <= '{off: bus.req_addr_i[1:0], size: size_e'(bus.req_size_i),
                       uns: bus.req_unsigned_i};
      end else if (issue) begin
        stg_vld <= 1'b0;
      end
    end
  end

  cache_lsu_fifo #(
    .DEPTH(MAX_OUTSTANDING),
    .WIDTH(META_W)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .din  (stg_meta),
    .dout (head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_vld  <= 1'b0;
      rsp_data <= '0;
    end else if (pop) begin
      rsp_vld  <= 1'b1;
      rsp_data <= load_align(bus.p0_ddat_i, head);
    end else if (bus.rsp_rdy_i) begin
      rsp_vld <= 1'b0;
    end
  end

`ifdef CACHE_LSU_TIMEOUT_EN
  logic [7:0] to_cnt;
  logic       to_flag;

  // Down-counter reloads whenever nothing is waiting or a response arrives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt  <= TIMEOUT_CYCLES;
      to_flag <= 1'b0;
    end else if (fifo_empty || pop) begin
      to_cnt <= TIMEOUT_CYCLES;
    end else if (to_cnt != 8'd0) begin
      to_cnt <= to_cnt - 8'd1;
      if (to_cnt == 8'd1) to_flag <= 1'b1;
    end
  end

  assign bus.timeout_o = to_flag;
`else
  assign bus.timeout_o = 1'b0;
`endif

  assign bus.req_rdy_o  = req_rdy;
  assign bus.p0_uvld_o  = uvld;
  assign bus.p0_addr_o  = stg_addr;
  assign bus.p0_web_o   = stg_web;
  assign bus.p0_wdat_o  = stg_wdat;
  assign bus.p0_wmask_o = stg_wmask;
  assign bus.p0_drdy_o  = !rsp_vld | bus.rsp_rdy_i;
  assign bus.rsp_vld_o  = rsp_vld;
  assign bus.rsp_data_o = rsp_data;
  assign bus.err_o      = err_q;

endmodule

// File: tb/tb_cache_lsu.sv
// Directed self-checking bench for cache_lsu (MAX_OUTSTANDING=2, TIMEOUT_CYCLES=10).
module tb_cache_lsu;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  cache_lsu_if bus();

  cache_lsu #(
    .MAX_OUTSTANDING(2),
    .TIMEOUT_CYCLES (8'd10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic idle_inputs;
    bus.req_vld_i      = 1'b0;
    bus.req_addr_i     = '0;
    bus.req_we_i       = 1'b0;
    bus.req_unsigned_i = 1'b0;
    bus.req_size_i     = 2'd0;
    bus.req_wdat_i     = '0;
    bus.rsp_rdy_i      = 1'b1;
    bus.p0_urdy_i      = 1'b1;
    bus.p0_dvld_i      = 1'b0;
    bus.p0_ddat_i      = '0;
  endtask

  task automatic send_req(input logic [31:0] a, input logic we, input logic [1:0] sz,
                          input logic uns, input logic [31:0] wd);
    bus.req_addr_i     = a;
    bus.req_we_i       = we;
    bus.req_size_i     = sz;
    bus.req_unsigned_i = uns;
    bus.req_wdat_i     = wd;
    bus.req_vld_i      = 1'b1;
    tick();
    bus.req_vld_i      = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle_inputs();
    repeat (3) tick();
    n_chk++; if (bus.req_rdy_o !== 1'b0) begin n_fail++; $display("FAIL rst_req_rdy: got %b exp 0", bus.req_rdy_o); end
    n_chk++; if (bus.p0_uvld_o !== 1'b0) begin n_fail++; $display("FAIL rst_uvld: got %b exp 0", bus.p0_uvld_o); end
    n_chk++; if (bus.rsp_vld_o !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_vld: got %b exp 0", bus.rsp_vld_o); end
    n_chk++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b exp 0", bus.err_o); end
    n_chk++; if (bus.timeout_o !== 1'b0) begin n_fail++; $display("FAIL rst_timeout: got %b exp 0", bus.timeout_o); end
    n_chk++; if (bus.rsp_data_o !== 32'h0) begin n_fail++; $display("FAIL rst_rsp_data: got %h exp 0", bus.rsp_data_o); end
    n_chk++; if (bus.p0_addr_o !== 32'h0) begin n_fail++; $display("FAIL rst_p0_addr: got %h exp 0", bus.p0_addr_o); end
    n_chk++; if (bus.p0_wdat_o !== 32'h0) begin n_fail++; $display("FAIL rst_p0_wdat: got %h exp 0", bus.p0_wdat_o); end
    n_chk++; if (bus.p0_wmask_o !== 4'h0) begin n_fail++; $display("FAIL rst_p0_wmask: got %h exp 0", bus.p0_wmask_o); end
    n_chk++; if (bus.p0_web_o !== 1'b0) begin n_fail++; $display("FAIL rst_p0_web: got %b exp 0", bus.p0_web_o); end
    reset = 1'b0;
    tick();
    n_chk++; if (bus.req_rdy_o !== 1'b1) begin n_fail++; $display("FAIL post_rst_req_rdy: got %b exp 1", bus.req_rdy_o); end
  endtask

  task automatic test_load_byte;
    idle_inputs();
    send_req(32'h103, 1'b0, 2'd0, 1'b0, 32'h0);
    n_chk++; if (bus.p0_uvld_o !== 1'b1) begin n_fail++; $display("FAIL lb_uvld: got %b exp 1", bus.p0_uvld_o); end
    n_chk++; if (bus.p0_addr_o !== 32'h100) begin n_fail++; $display("FAIL lb_addr: got %h exp 00000100", bus.p0_addr_o); end
    n_chk++; if (bus.p0_wmask_o !== 4'b0000) begin n_fail++; $display("FAIL lb_wmask: got %b exp 0000", bus.p0_wmask_o); end
    n_chk++; if (bus.p0_web_o !== 1'b1) begin n_fail++; $display("FAIL lb_web: got %b exp 1", bus.p0_web_o); end
    tick();
    n_chk++; if (bus.p0_uvld_o !== 1'b0) begin n_fail++; $display("FAIL lb_uvld_drop: got %b exp 0", bus.p0_uvld_o); end
    bus.p0_dvld_i = 1'b1;
    bus.p0_ddat_i = 32'h80AABBCC;
    settle();
    n_chk++; if (bus.p0_drdy_o !== 1'b1) begin n_fail++; $display("FAIL lb_drdy: got %b exp 1", bus.p0_drdy_o); end
    tick();
    bus.p0_dvld_i = 1'b0;
    n_chk++; if (bus.rsp_vld_o !== 1'b1) begin n_fail++; $display("FAIL lb_rsp_vld: got %b exp 1", bus.rsp_vld_o); end
    n_chk++; if (bus.rsp_data_o !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_rsp_data: got %h exp FFFFFF80", bus.rsp_data_o); end
    tick();
    n_chk++; if (bus.rsp_vld_o !== 1'b0) begin n_fail++; $display("FAIL lb_rsp_done: got %b exp 0", bus.rsp_vld_o); end
  endtask

  task automatic test_store_half;
    idle_inputs();
    bus.p0_urdy_i = 1'b0;
    send_req(32'h22, 1'b1, 2'd1, 1'b0, 32'h1234);
    n_chk++; if (bus.p0_uvld_o !== 1'b1) begin n_fail++; $display("FAIL sh_uvld: got %b exp 1", bus.p0_uvld_o); end
    n_chk++; if (bus.p0_web_o !== 1'b0) begin n_fail++; $display("FAIL sh_web: got %b exp 0", bus.p0_web_o); end
    n_chk++; if (bus.p0_wmask_o !== 4'b1100) begin n_fail++; $display("FAIL sh_wmask: got %b exp 1100", bus.p0_wmask_o); end
    n_chk++; if (bus.p0_wdat_o !== 32'h12341234) begin n_fail++; $display("FAIL sh_wdat: got %h exp 12341234", bus.p0_wdat_o); end
    n_chk++; if (bus.p0_addr_o !== 32'h20) begin n_fail++; $display("FAIL sh_addr: got %h exp 00000020", bus.p0_addr_o); end
    n_chk++; if (bus.req_rdy_o !== 1'b0) begin n_fail++; $display("FAIL sh_rdy_stall: got %b exp 0", bus.req_rdy_o); end
    tick();
    n_chk++; if (bus.p0_uvld_o !== 1'b1) begin n_fail++; $display("FAIL sh_uvld_hold: got %b exp 1", bus.p0_uvld_o); end
    n_chk++; if (bus.p0_wdat_o !== 32'h12341234) begin n_fail++; $display("FAIL sh_wdat_hold: got %h exp 12341234", bus.p0_wdat_o); end
    bus.p0_urdy_i = 1'b1;
    settle();
    n_chk++; if (bus.req_rdy_o !== 1'b1) begin n_fail++; $display("FAIL sh_rdy_drain: got %b exp 1", bus.req_rdy_o); end
    tick();
    n_chk++; if (bus.p0_uvld_o !== 1'b0) begin n_fail++; $display("FAIL sh_uvld_done: got %b exp 0", bus.p0_uvld_o); end
    bus.p0_dvld_i = 1'b1;
    bus.p0_ddat_i = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++; if (bus.rsp_vld_o !== 1'b0) begin n_fail++; $display("FAIL sh_no_rsp[%0d]: got %b exp 0", i, bus.rsp_vld_o); end
    end
    bus.p0_dvld_i = 1'b0;
  endtask

  task automatic test_misaligned;
    logic [31:0] addrs [3];
    logic [1:0]  sizes [3];
    addrs = '{32'h2, 32'h101, 32'h100};
    sizes = '{2'd2, 2'd1, 2'd3};
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      bus.req_addr_i = addrs[i];
      bus.req_size_i = sizes[i];
      bus.req_we_i   = 1'b0;
      bus.req_vld_i  = 1'b1;
      settle();
      n_chk++; if (bus.req_rdy_o !== 1'b1) begin n_fail++; $display("FAIL mis_rdy[%0d]: got %b exp 1", i, bus.req_rdy_o); end
      tick();
      bus.req_vld_i = 1'b0;
      n_chk++; if (bus.err_o !== 1'b1) begin n_fail++; $display("FAIL mis_err[%0d]: got %b exp 1", i, bus.err_o); end
      n_chk++; if (bus.p0_uvld_o !== 1'b0) begin n_fail++; $display("FAIL mis_uvld[%0d]: got %b exp 0", i, bus.p0_uvld_o); end
      tick();
      n_chk++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL mis_err_pulse[%0d]: got %b exp 0", i, bus.err_o); end
      n_chk++; if (bus.rsp_vld_o !== 1'b0) begin n_fail++; $display("FAIL mis_rsp[%0d]: got %b exp 0", i, bus.rsp_vld_o); end
    end
  endtask

  task automatic test_back_to_back;
    idle_inputs();
    bus.req_size_i = 2'd2;
    bus.req_addr_i = 32'h10;
    bus.req_vld_i  = 1'b1;
    tick();
    bus.req_addr_i = 32'h20;
    settle();
    n_chk++; if (bus.p0_uvld_o !== 1'b1) begin n_fail++; $display("FAIL b2b_uvld_a: got %b exp 1", bus.p0_uvld_o); end
    n_chk++; if (bus.req_rdy_o !== 1'b1) begin n_fail++; $display("FAIL b2b_rdy_a: got %b exp 1", bus.req_rdy_o); end
    tick();
    bus.req_addr_i = 32'h30;
    settle();
    n_chk++; if (bus.p0_uvld_o !== 1'b1) begin n_fail++; $display("FAIL b2b_uvld_b: got %b exp 1", bus.p0_uvld_o); end
    tick();
    bus.req_vld_i = 1'b0;
    n_chk++; if (bus.p0_uvld_o !== 1'b0) begin n_fail++; $display("FAIL b2b_uvld_c_stall: got %b exp 0", bus.p0_uvld_o); end
    n_chk++; if (bus.req_rdy_o !== 1'b0) begin n_fail++; $display("FAIL b2b_rdy_stall: got %b exp 0", bus.req_rdy_o); end
    tick();
    tick();
    n_chk++; if (bus.p0_uvld_o !== 1'b0) begin n_fail++; $display("FAIL b2b_uvld_c_wait: got %b exp 0", bus.p0_uvld_o); end
    n_chk++; if (bus.p0_addr_o !== 32'h30) begin n_fail++; $display("FAIL b2b_addr_c: got %h exp 00000030", bus.p0_addr_o); end
    bus.p0_dvld_i = 1'b1;
    bus.p0_ddat_i = 32'h11111111;
    settle();
    n_chk++; if (bus.p0_uvld_o !== 1'b1) begin n_fail++; $display("FAIL b2b_uvld_c_free: got %b exp 1", bus.p0_uvld_o); end
    tick();
    bus.p0_ddat_i = 32'h22222222;
    n_chk++; if (bus.rsp_vld_o !== 1'b1) begin n_fail++; $display("FAIL b2b_rsp_vld_a: got %b exp 1", bus.rsp_vld_o); end
    n_chk++; if (bus.rsp_data_o !== 32'h11111111) begin n_fail++; $display("FAIL b2b_rsp_a: got %h exp 11111111", bus.rsp_data_o); end
    n_chk++; if (bus.p0_uvld_o !== 1'b0) begin n_fail++; $display("FAIL b2b_uvld_c_done: got %b exp 0", bus.p0_uvld_o); end
    tick();
    bus.p0_ddat_i = 32'h33333333;
    n_chk++; if (bus.rsp_data_o !== 32'h22222222) begin n_fail++; $display("FAIL b2b_rsp_b: got %h exp 22222222", bus.rsp_data_o); end
    tick();
    bus.p0_dvld_i = 1'b0;
    n_chk++; if (bus.rsp_data_o !== 32'h33333333) begin n_fail++; $display("FAIL b2b_rsp_c: got %h exp 33333333", bus.rsp_data_o); end
    tick();
    n_chk++; if (bus.rsp_vld_o !== 1'b0) begin n_fail++; $display("FAIL b2b_rsp_done: got %b exp 0", bus.rsp_vld_o); end
  endtask

  task automatic test_rsp_backpressure;
    idle_inputs();
    bus.rsp_rdy_i = 1'b0;
    send_req(32'h101, 1'b0, 2'd0, 1'b1, 32'h0);
    tick();
    send_req(32'h102, 1'b0, 2'd1, 1'b0, 32'h0);
    tick();
    bus.p0_dvld_i = 1'b1;
    bus.p0_ddat_i = 32'hDEADBEEF;
    tick();
    bus.p0_ddat_i = 32'h8001CAFE;
    n_chk++; if (bus.rsp_vld_o !== 1'b1) begin n_fail++; $display("FAIL bp_rsp_vld: got %b exp 1", bus.rsp_vld_o); end
    n_chk++; if (bus.rsp_data_o !== 32'h000000BE) begin n_fail++; $display("FAIL bp_rsp_data: got %h exp 000000BE", bus.rsp_data_o); end
    n_chk++; if (bus.p0_drdy_o !== 1'b0) begin n_fail++; $display("FAIL bp_drdy: got %b exp 0", bus.p0_drdy_o); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++; if (bus.rsp_data_o !== 32'h000000BE) begin n_fail++; $display("FAIL bp_hold_data[%0d]: got %h exp 000000BE", i, bus.rsp_data_o); end
      n_chk++; if (bus.p0_drdy_o !== 1'b0) begin n_fail++; $display("FAIL bp_hold_drdy[%0d]: got %b exp 0", i, bus.p0_drdy_o); end
    end
    bus.rsp_rdy_i = 1'b1;
    settle();
    n_chk++; if (bus.p0_drdy_o !== 1'b1) begin n_fail++; $display("FAIL bp_drdy_release: got %b exp 1", bus.p0_drdy_o); end
    tick();
    bus.p0_dvld_i = 1'b0;
    n_chk++; if (bus.rsp_vld_o !== 1'b1) begin n_fail++; $display("FAIL bp_rsp2_vld: got %b exp 1", bus.rsp_vld_o); end
    n_chk++; if (bus.rsp_data_o !== 32'hFFFF8001) begin n_fail++; $display("FAIL bp_rsp2_data: got %h exp FFFF8001", bus.rsp_data_o); end
    tick();
    n_chk++; if (bus.rsp_vld_o !== 1'b0) begin n_fail++; $display("FAIL bp_rsp_done: got %b exp 0", bus.rsp_vld_o); end
  endtask

`ifdef CACHE_LSU_TIMEOUT_EN
  task automatic test_timeout;
    do_reset();
    send_req(32'h200, 1'b0, 2'd2, 1'b0, 32'h0);
    repeat (10) tick();
    n_chk++; if (bus.timeout_o !== 1'b0) begin n_fail++; $display("FAIL to_early: got %b exp 0", bus.timeout_o); end
    tick();
    n_chk++; if (bus.timeout_o !== 1'b1) begin n_fail++; $display("FAIL to_set: got %b exp 1", bus.timeout_o); end
    repeat (3) tick();
    n_chk++; if (bus.timeout_o !== 1'b1) begin n_fail++; $display("FAIL to_hold: got %b exp 1", bus.timeout_o); end
    bus.p0_dvld_i = 1'b1;
    bus.p0_ddat_i = 32'h5A5A5A5A;
    tick();
    bus.p0_dvld_i = 1'b0;
    n_chk++; if (bus.timeout_o !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b exp 1", bus.timeout_o); end
    n_chk++; if (bus.rsp_data_o !== 32'h5A5A5A5A) begin n_fail++; $display("FAIL to_late_rsp: got %h exp 5A5A5A5A", bus.rsp_data_o); end
    do_reset();
    n_chk++; if (bus.timeout_o !== 1'b0) begin n_fail++; $display("FAIL to_cleared: got %b exp 0", bus.timeout_o); end
  endtask
`else
  task automatic test_timeout;
    do_reset();
    send_req(32'h200, 1'b0, 2'd2, 1'b0, 32'h0);
    repeat (15) tick();
    n_chk++; if (bus.timeout_o !== 1'b0) begin n_fail++; $display("FAIL to_disabled: got %b exp 0", bus.timeout_o); end
    do_reset();
  endtask
`endif

  task automatic test_reset_midflight;
    idle_inputs();
    send_req(32'h300, 1'b0, 2'd2, 1'b0, 32'h0);
    tick();
    bus.p0_urdy_i = 1'b0;
    send_req(32'h304, 1'b0, 2'd2, 1'b0, 32'h0);
    n_chk++; if (bus.p0_uvld_o !== 1'b1) begin n_fail++; $display("FAIL mid_uvld_pre: got %b exp 1", bus.p0_uvld_o); end
    reset = 1'b1;
    settle();
    n_chk++; if (bus.p0_uvld_o !== 1'b0) begin n_fail++; $display("FAIL mid_uvld_async: got %b exp 0", bus.p0_uvld_o); end
    tick();
    reset = 1'b0;
    bus.p0_urdy_i = 1'b1;
    tick();
    n_chk++; if (bus.p0_uvld_o !== 1'b0) begin n_fail++; $display("FAIL mid_uvld_post: got %b exp 0", bus.p0_uvld_o); end
    bus.p0_dvld_i = 1'b1;
    bus.p0_ddat_i = 32'hCAFEF00D;
    tick();
    tick();
    bus.p0_dvld_i = 1'b0;
    n_chk++; if (bus.rsp_vld_o !== 1'b0) begin n_fail++; $display("FAIL mid_late_dvld: got %b exp 0", bus.rsp_vld_o); end
    n_chk++; if (bus.rsp_data_o !== 32'h0) begin n_fail++; $display("FAIL mid_rsp_data: got %h exp 0", bus.rsp_data_o); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    test_reset();
    test_load_byte();
    test_store_half();
    test_misaligned();
    test_back_to_back();
    test_rsp_backpressure();
    test_timeout();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
